// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the instruction fetch slice.
//   A          : program-counter / instruction-address width
//   W          : instruction word width
//   HALT_INST  : all-ones instruction word that stops fetching
//   state_t    : fetch FSM state encoding (IDLE, RUN, HALTED)
// -----------------------------------------------------------------------------
package isa_pkg;

    localparam int A = 16;
    localparam int W = 9;

    localparam logic [W-1:0] HALT_INST = 9'b111_11_11_11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage : isa_pkg

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Single-stage instruction fetch unit. Drives the program counter straight to
// an external combinational instruction ROM and registers the returned word
// into a valid/ready output stage for the decoder.
//
// Ports
//   Clk          : clock, all state updates on the rising edge
//   Reset        : asynchronous active-high reset
//   Start        : pulse; (re)starts execution at address 0 from IDLE/HALTED
//   InstAddress  : ROM address, equal to the program counter
//   InstIn       : ROM word for InstAddress, valid in the same cycle
//   BranchEn     : redirect request; flushes the output stage
//   Target       : absolute redirect address
//   OutReady     : decoder accepts OutInst this cycle
//   OutValid     : OutInst/OutPC hold a fetched instruction
//   OutInst      : registered instruction word
//   OutPC        : address OutInst was fetched from
//   Done         : halted and the halt word has been consumed
//   InstCount    : saturating count of words accepted downstream
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int A = isa_pkg::A,
    parameter int W = isa_pkg::W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    output logic [A-1:0] InstAddress,
    input  logic [W-1:0] InstIn,
    input  logic         BranchEn,
    input  logic [A-1:0] Target,
    input  logic         OutReady,
    output logic         OutValid,
    output logic [W-1:0] OutInst,
    output logic [A-1:0] OutPC,
    output logic         Done,
    output logic [A-1:0] InstCount
);

    import isa_pkg::*;

    state_t         state_reg, state_next;
    logic [A-1:0]   pc_reg, pc_next;
    logic           out_valid_reg, out_valid_next;
    logic [W-1:0]   out_inst_reg, out_inst_next;
    logic [A-1:0]   out_pc_reg, out_pc_next;
    logic [A-1:0]   count_reg, count_next;

    logic           fire;
    logic           accept;
    logic           is_halt;

    // HALT_INST is the all-ones word; reducing with AND keeps the test
    // correct for any instruction width the block is built with.
    assign is_halt = &InstIn;

    // A new word is captured only while running, not being redirected, and
    // the output stage is empty or being emptied this cycle.
    assign fire = (state_reg == RUN) && !BranchEn && (!out_valid_reg || OutReady);

    // A word is consumed downstream when the handshake completes, unless a
    // redirect in RUN flushes it. BranchEn has no effect once halted, so the
    // draining halt word is always counted.
    assign accept = out_valid_reg && OutReady && !(BranchEn && (state_reg == RUN));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            pc_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_inst_reg  <= '0;
            out_pc_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            out_valid_reg <= out_valid_next;
            out_inst_reg  <= out_inst_next;
            out_pc_reg    <= out_pc_next;
            count_reg     <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        out_valid_next = out_valid_reg;
        out_inst_next  = out_inst_reg;
        out_pc_next    = out_pc_reg;
        count_next     = count_reg;

        unique case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next     = RUN;
                    pc_next        = '0;
                    out_valid_next = 1'b0;
                    count_next     = '0;
                end
            end

            RUN: begin
                if (accept && (count_reg != {A{1'b1}})) begin
                    count_next = count_reg + A'(1);
                end

                if (BranchEn) begin
                    // Redirect wins over fetch and stall; the word in the
                    // output stage belongs to the wrong path.
                    pc_next        = Target;
                    out_valid_next = 1'b0;
                end else if (fire) begin
                    out_inst_next  = InstIn;
                    out_pc_next    = pc_reg;
                    out_valid_next = 1'b1;
                    if (is_halt) begin
                        // PC stays on the halt word's address.
                        state_next = HALTED;
                    end else begin
                        pc_next = pc_reg + A'(1);
                    end
                end else if (out_valid_reg && OutReady) begin
                    out_valid_next = 1'b0;
                end
            end

            HALTED: begin
                if (Start) begin
                    state_next     = RUN;
                    pc_next        = '0;
                    out_valid_next = 1'b0;
                    count_next     = '0;
                end else if (accept) begin
                    // Only the halt word can still be pending here.
                    out_valid_next = 1'b0;
                    if (count_reg != {A{1'b1}}) begin
                        count_next = count_reg + A'(1);
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign InstAddress = pc_reg;
    assign OutValid    = out_valid_reg;
    assign OutInst     = out_inst_reg;
    assign OutPC       = out_pc_reg;
    assign InstCount   = count_reg;
    assign Done        = (state_reg == HALTED) && !out_valid_reg;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. A behavioural ROM sits beside the DUT: words
// below halt_addr (and at 16'hFFFF) are ordinary instructions, everything else
// reads as the all-ones halt word.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int A = 16;
    localparam int W = 9;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [A-1:0] InstAddress;
    logic [W-1:0] InstIn;
    logic         BranchEn;
    logic [A-1:0] Target;
    logic         OutReady;
    logic         OutValid;
    logic [W-1:0] OutInst;
    logic [A-1:0] OutPC;
    logic         Done;
    logic [A-1:0] InstCount;

    logic [A-1:0] halt_addr;
    int           total = 0;
    int           bad   = 0;

    always #5 Clk = ~Clk;

    inst_fetch #(.A(A), .W(W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .InstAddress (InstAddress),
        .InstIn      (InstIn),
        .BranchEn    (BranchEn),
        .Target      (Target),
        .OutReady    (OutReady),
        .OutValid    (OutValid),
        .OutInst     (OutInst),
        .OutPC       (OutPC),
        .Done        (Done),
        .InstCount   (InstCount)
    );

    // Ordinary words have MSB 0, so they can never be mistaken for halt.
    function automatic logic [W-1:0] rom_word(input logic [A-1:0] a);
        return {1'b0, a[7:0] ^ 8'h3C};
    endfunction

    assign InstIn = ((InstAddress < halt_addr) || (InstAddress == 16'hFFFF))
                    ? rom_word(InstAddress) : 9'h1FF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            $display("ok   %s obs=%h", tag, obs);
        else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [A-1:0] pc);
        chk({tag, "_valid"}, 32'(OutValid), 32'd1);
        chk({tag, "_pc"},    32'(OutPC),    32'(pc));
        chk({tag, "_inst"},  32'(OutInst),  32'(rom_word(pc)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        BranchEn  = 1'b0;
        Target    = '0;
        OutReady  = 1'b1;
        halt_addr = 16'd8;
        #1;
        chk("rst_valid", 32'(OutValid),    32'd0);
        chk("rst_done",  32'(Done),        32'd0);
        chk("rst_count", 32'(InstCount),   32'd0);
        chk("rst_addr",  32'(InstAddress), 32'd0);
        chk("rst_pc",    32'(OutPC),       32'd0);
        chk("rst_inst",  32'(OutInst),     32'd0);
        tick();
        tick();
        Reset = 1'b0;
        tick();
        chk("idle_valid", 32'(OutValid),    32'd0);
        chk("idle_addr",  32'(InstAddress), 32'd0);

        // Straight-line program: words 0..7 then halt at 8.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start_valid", 32'(OutValid),    32'd0);
        chk("start_addr",  32'(InstAddress), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("seq", A'(i));
            chk("seq_done", 32'(Done), 32'd0);
        end
        tick();
        chk("halt_valid", 32'(OutValid), 32'd1);
        chk("halt_pc",    32'(OutPC),    32'd8);
        chk("halt_inst",  32'(OutInst),  32'h1FF);
        chk("halt_done0", 32'(Done),     32'd0);
        tick();
        chk("halt_drain_valid", 32'(OutValid),    32'd0);
        chk("halt_drain_done",  32'(Done),        32'd1);
        chk("halt_count",       32'(InstCount),   32'd9);
        chk("halt_addr_hold",   32'(InstAddress), 32'd8);

        // Restart from HALTED with a long program.
        halt_addr = 16'h0100;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("restart_count", 32'(InstCount), 32'd0);
        chk("restart_done",  32'(Done),      32'd0);
        tick();
        tick();
        tick();
        chk_out("pre_stall", 16'd2);

        // Stall three cycles at OutPC=2.
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall", 16'd2);
            chk("stall_addr", 32'(InstAddress), 32'd3);
        end
        OutReady = 1'b1;
        tick();
        chk_out("resume", 16'd3);
        chk("resume_count", 32'(InstCount), 32'd3);

        // Redirect back to 0, run to OutPC=2, then redirect to 5.
        BranchEn = 1'b1;
        Target   = 16'h0000;
        tick();
        BranchEn = 1'b0;
        chk("br0_valid", 32'(OutValid),  32'd0);
        chk("br0_count", 32'(InstCount), 32'd3);
        tick();
        tick();
        tick();
        chk_out("br_pre", 16'd2);
        chk("br_pre_count", 32'(InstCount), 32'd5);
        BranchEn = 1'b1;
        Target   = 16'h0005;
        tick();
        BranchEn = 1'b0;
        chk("br5_valid", 32'(OutValid),    32'd0);
        chk("br5_addr",  32'(InstAddress), 32'd5);
        chk("br5_count", 32'(InstCount),   32'd5);
        tick();
        chk_out("br5_tgt", 16'd5);
        chk("br5_tgt_count", 32'(InstCount), 32'd5);
        tick();
        chk_out("br5_next", 16'd6);
        chk("br5_next_count", 32'(InstCount), 32'd6);

        // Start while running must be ignored.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk_out("start_in_run", 16'd7);
        chk("start_in_run_count", 32'(InstCount), 32'd7);

        // Redirect to the top of the address space and wrap.
        BranchEn = 1'b1;
        Target   = 16'hFFFF;
        tick();
        BranchEn = 1'b0;
        chk("wrap_flush_valid", 32'(OutValid), 32'd0);
        tick();
        chk_out("wrap_top", 16'hFFFF);
        chk("wrap_addr", 32'(InstAddress), 32'd0);
        tick();
        chk_out("wrap_zero", 16'h0000);
        chk("wrap_count", 32'(InstCount), 32'd8);

        // Asynchronous reset between edges.
        #2;
        Reset = 1'b1;
        #1;
        chk("areset_valid", 32'(OutValid),    32'd0);
        chk("areset_pc",    32'(OutPC),       32'd0);
        chk("areset_inst",  32'(OutInst),     32'd0);
        chk("areset_count", 32'(InstCount),   32'd0);
        chk("areset_done",  32'(Done),        32'd0);
        chk("areset_addr",  32'(InstAddress), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("post_reset_idle", 32'(OutValid), 32'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        chk_out("post_reset_fetch", 16'd0);

        // Halt at 3, then redirect attempts while the halt word is stalled.
        halt_addr = 16'd3;
        tick();
        chk_out("h_seq", 16'd1);
        tick();
        chk_out("h_seq", 16'd2);
        tick();
        chk("h_word_valid", 32'(OutValid), 32'd1);
        chk("h_word_pc",    32'(OutPC),    32'd3);
        chk("h_word_inst",  32'(OutInst),  32'h1FF);
        OutReady = 1'b0;
        BranchEn = 1'b1;
        Target   = 16'h0010;
        tick();
        BranchEn = 1'b0;
        chk("h_br_valid", 32'(OutValid),    32'd1);
        chk("h_br_inst",  32'(OutInst),     32'h1FF);
        chk("h_br_pc",    32'(OutPC),       32'd3);
        chk("h_br_addr",  32'(InstAddress), 32'd3);
        chk("h_br_done",  32'(Done),        32'd0);
        tick();
        chk("h_hold_valid", 32'(OutValid),    32'd1);
        chk("h_hold_addr",  32'(InstAddress), 32'd3);
        OutReady = 1'b1;
        tick();
        chk("h_drain_valid", 32'(OutValid),    32'd0);
        chk("h_drain_done",  32'(Done),        32'd1);
        chk("h_drain_addr",  32'(InstAddress), 32'd3);
        chk("h_drain_count", 32'(InstCount),   32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_inst_fetch
